// File: rtl/uart_frame_core.sv
// uart_frame_core: parametrised full-duplex UART.
// TX and RX are independent state machines sharing only the clock and reset.
// Frame = start + DATA_BITS (LSB first) + optional parity + STOP_BITS stops.
// RX samples each bit at its midpoint and reports parity and framing errors
// alongside the received data.
module uart_frame_core #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_byte,
  output logic                 o_tx_active,
  output logic                 o_tx,
  output logic                 o_tx_done,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_rx_done,
  output logic                 o_rx_parity_err,
  output logic                 o_rx_frame_err
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam int              HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic            HAS_PAR   = (PARITY != 0);
  localparam logic            ODD_PAR   = (PARITY == 1);

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_PARITY    = 3'd3;
  localparam logic [2:0] RX_STOP      = 3'd4;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd5;

  // ---------------------------------------------------------------- TX
  logic [2:0]           tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_active_q, tx_active_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_bit_end;

  // TX next-state: the line value for the next bit is registered on the
  // bit boundary so o_tx comes straight from a flop.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_line_d   = tx_line_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    tx_bit_end  = (tx_cnt_q == CNT_LAST);

    if (tx_state_q != TX_IDLE) begin
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CNT_ONE;
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (i_tx_start) begin
          tx_state_d  = TX_START;
          tx_cnt_d    = '0;
          tx_shift_d  = i_tx_byte;
          tx_par_d    = (^i_tx_byte) ^ ODD_PAR;
          tx_line_d   = 1'b0;
          tx_active_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == DATA_LAST) begin
            if (HAS_PAR) begin
              tx_state_d = TX_PARITY;
              tx_line_d  = tx_par_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_line_d  = 1'b1;
              tx_bit_d   = '0;
            end
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
          tx_bit_d   = '0;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d  = TX_IDLE;
            tx_active_d = 1'b0;
            tx_done_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end
      end
      default: begin
        tx_state_d  = TX_IDLE;
        tx_line_d   = 1'b1;
        tx_active_d = 1'b0;
      end
    endcase
  end

  // TX state registers; reset drops any frame in flight with no done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
      tx_par_q    <= 1'b0;
      tx_line_q   <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_par_q    <= tx_par_d;
      tx_line_q   <= tx_line_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign o_tx        = tx_line_q;
  assign o_tx_active = tx_active_q;
  assign o_tx_done   = tx_done_q;

  // ---------------------------------------------------------------- RX
  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_stop_err_q, rx_stop_err_d;
  logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
  logic                 rx_done_q, rx_done_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_sample;
  logic                 rx_ferr_now;
  logic                 rx_exp_par;

  // Two-flop synchroniser; both stages idle high so reset looks like a quiet line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_exp_par = (^rx_shift_q) ^ ODD_PAR;

  // RX next-state: confirm the start bit at its midpoint, then sample every
  // CLKS_PER_BIT cycles; results publish together after the last stop bit.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q + CNT_ONE;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_par_d      = rx_par_q;
    rx_stop_err_d = rx_stop_err_q;
    rx_byte_d     = rx_byte_q;
    rx_done_d     = 1'b0;
    rx_perr_d     = rx_perr_q;
    rx_ferr_d     = rx_ferr_q;
    rx_sample     = (rx_cnt_q == CNT_LAST);
    rx_ferr_now   = rx_stop_err_q | ~rx_sync_q;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            rx_state_d    = RX_DATA;
            rx_bit_d      = '0;
            rx_stop_err_d = 1'b0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_bit_q == DATA_LAST) begin
            rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
            rx_bit_d   = '0;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
          rx_bit_d   = '0;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_cnt_d = '0;
          if (rx_bit_q == STOP_LAST) begin
            rx_byte_d  = rx_shift_q;
            rx_perr_d  = HAS_PAR & (rx_par_q != rx_exp_par);
            rx_ferr_d  = rx_ferr_now;
            rx_done_d  = 1'b1;
            rx_state_d = rx_ferr_now ? RX_WAIT_HIGH : RX_IDLE;
          end else begin
            rx_stop_err_d = rx_ferr_now;
            rx_bit_d      = rx_bit_q + 4'd1;
          end
        end
      end
      RX_WAIT_HIGH: begin
        // A break keeps the line low; re-arm only on a real idle level.
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_state_q    <= RX_IDLE;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_stop_err_q <= 1'b0;
      rx_byte_q     <= '0;
      rx_done_q     <= 1'b0;
      rx_perr_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_q      <= rx_par_d;
      rx_stop_err_q <= rx_stop_err_d;
      rx_byte_q     <= rx_byte_d;
      rx_done_q     <= rx_done_d;
      rx_perr_q     <= rx_perr_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  assign o_rx_byte       = rx_byte_q;
  assign o_rx_done       = rx_done_q;
  assign o_rx_parity_err = rx_perr_q;
  assign o_rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_frame_core.sv
// Directed bench for uart_frame_core.
// u_a: 8N1 at 87 clocks/bit, TX looped back to RX.
// u_b: 8E1 at 4 clocks/bit, TX looped back to RX.
// u_c: 7O2 at 4 clocks/bit, RX driven bit by bit from the bench.
module tb_uart_frame_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // u_a
  logic       start_a = 1'b0;
  logic [7:0] byte_a  = 8'h00;
  logic       active_a, tx_a, tx_done_a, rx_done_a, perr_a, ferr_a;
  logic [7:0] rx_byte_a;

  uart_frame_core #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start_a), .i_tx_byte(byte_a),
    .o_tx_active(active_a), .o_tx(tx_a), .o_tx_done(tx_done_a), .i_rx(tx_a),
    .o_rx_byte(rx_byte_a), .o_rx_done(rx_done_a),
    .o_rx_parity_err(perr_a), .o_rx_frame_err(ferr_a));

  // u_b
  logic       start_b = 1'b0;
  logic [7:0] byte_b  = 8'h00;
  logic       active_b, tx_b, tx_done_b, rx_done_b, perr_b, ferr_b;
  logic [7:0] rx_byte_b;

  uart_frame_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start_b), .i_tx_byte(byte_b),
    .o_tx_active(active_b), .o_tx(tx_b), .o_tx_done(tx_done_b), .i_rx(tx_b),
    .o_rx_byte(rx_byte_b), .o_rx_done(rx_done_b),
    .o_rx_parity_err(perr_b), .o_rx_frame_err(ferr_b));

  // u_c
  logic       start_c = 1'b0;
  logic [6:0] byte_c  = 7'h00;
  logic       rx_c    = 1'b1;
  logic       active_c, tx_c, tx_done_c, rx_done_c, perr_c, ferr_c;
  logic [6:0] rx_byte_c;

  uart_frame_core #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .i_clk(clk), .i_rst(rst), .i_tx_start(start_c), .i_tx_byte(byte_c),
    .o_tx_active(active_c), .o_tx(tx_c), .o_tx_done(tx_done_c), .i_rx(rx_c),
    .o_rx_byte(rx_byte_c), .o_rx_done(rx_done_c),
    .o_rx_parity_err(perr_c), .o_rx_frame_err(ferr_c));

  // Pulse counters (each reads the value held during the cycle before the edge).
  int n_txdone_a = 0;
  int n_rxdone_a = 0;
  int n_rxdone_c = 0;
  always @(posedge clk) begin
    if (tx_done_a) n_txdone_a <= n_txdone_a + 1;
    if (rx_done_a) n_rxdone_a <= n_rxdone_a + 1;
    if (rx_done_c) n_rxdone_c <= n_rxdone_c + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Hold one bit on u_c's RX input for a full bit time.
  task automatic drive_bit_c(input logic b);
    rx_c = b;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // One 7O2 frame; flip inverts the parity bit. Line is left at the last stop level.
  task automatic send_c(input logic [6:0] d, input logic flip, input logic s0, input logic s1);
    drive_bit_c(1'b0);
    for (int i = 0; i < 7; i++) drive_bit_c(d[i]);
    drive_bit_c(~(^d) ^ flip);
    drive_bit_c(s0);
    drive_bit_c(s1);
  endtask

  // 8E1 loopback frame on u_b: start accepted at edge k, RX done and TX done
  // both visible in the cycle after edge k+44 (11 bits x 4 clocks; RX path
  // 1 + 2 + 1 + 10*4 = 44 edges from k).
  task automatic do_b(input logic [7:0] d, input logic par);
    int early;
    early   = 0;
    start_b = 1'b1;
    byte_b  = d;
    @(posedge clk);
    #1 start_b = 1'b0;
    for (int j = 0; j <= 44; j++) begin
      if (j > 0) @(posedge clk);
      @(negedge clk);
      if (j == 0) begin
        check("b_start_line", 32'(tx_b), 32'd0);
        check("b_active", 32'(active_b), 32'd1);
      end
      if (j == 38) check("b_parity_line", 32'(tx_b), 32'(par));
      if (j < 44 && rx_done_b) early++;
      if (j == 44) begin
        check("b_rx_done", 32'(rx_done_b), 32'd1);
        check("b_rx_byte", 32'(rx_byte_b), 32'(d));
        check("b_rx_perr", 32'(perr_b), 32'd0);
        check("b_rx_ferr", 32'(ferr_b), 32'd0);
        check("b_tx_done", 32'(tx_done_b), 32'd1);
      end
    end
    check("b_rx_early", 32'(early), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] exp_a;
    int hold [10];
    int act, early_done, snap_tx, snap_rx, snap_rxc;

    // ---- reset state
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_line", 32'(tx_a), 32'd1);
    check("rst_tx_active", 32'(active_a), 32'd0);
    check("rst_tx_done", 32'(tx_done_a), 32'd0);
    check("rst_rx_byte", 32'(rx_byte_a), 32'd0);
    check("rst_rx_done", 32'(rx_done_c), 32'd0);
    check("rst_rx_flags", 32'({perr_c, ferr_c}), 32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // ---- 8N1 TX of 0xA5 at 87 clocks/bit, with a start pulse mid-frame
    exp_a = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) hold[b] = 0;
    act = 0;
    early_done = 0;
    snap_tx = n_txdone_a;
    snap_rx = n_rxdone_a;
    @(negedge clk);
    start_a = 1'b1;
    byte_a  = 8'hA5;
    @(posedge clk);
    #1 start_a = 1'b0;
    byte_a = 8'h00;
    for (int j = 0; j < 870; j++) begin
      @(negedge clk);
      if (tx_a == exp_a[j / 87]) hold[j / 87]++;
      if (active_a) act++;
      if (tx_done_a) early_done++;
      if (j == 300) begin
        start_a = 1'b1;
        byte_a  = 8'hFF;
      end
      if (j == 301) start_a = 1'b0;
    end
    for (int b = 0; b < 10; b++) check($sformatf("a_bit%0d_cycles", b), 32'(hold[b]), 32'd87);
    check("a_active_cycles", 32'(act), 32'd870);
    check("a_done_early", 32'(early_done), 32'd0);
    @(negedge clk);
    check("a_done_pulse", 32'(tx_done_a), 32'd1);
    check("a_active_end", 32'(active_a), 32'd0);
    @(negedge clk);
    check("a_done_width", 32'(tx_done_a), 32'd0);
    repeat (100) @(negedge clk);
    check("a_no_queued_start", 32'(active_a), 32'd0);
    check("a_done_count", 32'(n_txdone_a - snap_tx), 32'd1);
    check("a_rx_count", 32'(n_rxdone_a - snap_rx), 32'd1);
    check("a_rx_byte", 32'(rx_byte_a), 32'hA5);
    check("a_rx_ferr", 32'(ferr_a), 32'd0);

    // ---- 8E1 loopback; second start lands in the o_tx_done cycle
    @(negedge clk);
    do_b(8'h37, 1'b1);
    do_b(8'h81, 1'b0);

    // ---- 7O2: inverted parity, then a clean frame clears the flag
    @(posedge clk);
    #1 snap_rxc = n_rxdone_c;
    send_c(7'h55, 1'b1, 1'b1, 1'b1);
    rx_c = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("c_perr_count", 32'(n_rxdone_c - snap_rxc), 32'd1);
    check("c_perr_byte", 32'(rx_byte_c), 32'h55);
    check("c_perr_flag", 32'(perr_c), 32'd1);
    check("c_perr_ferr", 32'(ferr_c), 32'd0);
    @(posedge clk);
    #1 snap_rxc = n_rxdone_c;
    send_c(7'h2A, 1'b0, 1'b1, 1'b1);
    rx_c = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("c_clean_count", 32'(n_rxdone_c - snap_rxc), 32'd1);
    check("c_clean_byte", 32'(rx_byte_c), 32'h2A);
    check("c_clean_perr", 32'(perr_c), 32'd0);

    // ---- stop bits low, then a 5-bit-time break: exactly one error frame
    @(posedge clk);
    #1 snap_rxc = n_rxdone_c;
    send_c(7'h11, 1'b0, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 rx_c = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("c_break_count", 32'(n_rxdone_c - snap_rxc), 32'd1);
    check("c_break_ferr", 32'(ferr_c), 32'd1);
    check("c_break_byte", 32'(rx_byte_c), 32'h11);
    check("c_break_perr", 32'(perr_c), 32'd0);
    @(posedge clk);
    #1 snap_rxc = n_rxdone_c;
    send_c(7'h3C, 1'b0, 1'b1, 1'b1);
    rx_c = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("c_after_break_count", 32'(n_rxdone_c - snap_rxc), 32'd1);
    check("c_after_break_byte", 32'(rx_byte_c), 32'h3C);
    check("c_after_break_ferr", 32'(ferr_c), 32'd0);

    // ---- one-cycle glitch is rejected
    @(posedge clk);
    #1 snap_rxc = n_rxdone_c;
    rx_c = 1'b0;
    @(posedge clk);
    #1 rx_c = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("c_glitch_count", 32'(n_rxdone_c - snap_rxc), 32'd0);
    check("c_glitch_byte", 32'(rx_byte_c), 32'h3C);

    // ---- asynchronous reset mid-frame on TX and RX
    @(negedge clk);
    start_a = 1'b1;
    byte_a  = 8'h5A;
    @(posedge clk);
    #1 start_a = 1'b0;
    rx_c = 1'b0;
    repeat (300) @(posedge clk);
    check("rst_pre_active", 32'(active_a), 32'd1);
    snap_tx  = n_txdone_a;
    snap_rx  = n_rxdone_a;
    snap_rxc = n_rxdone_c;
    #3 rst = 1'b1;
    #1;
    check("rst_mid_tx_line", 32'(tx_a), 32'd1);
    check("rst_mid_active", 32'(active_a), 32'd0);
    check("rst_mid_tx_done", 32'(tx_done_a), 32'd0);
    check("rst_mid_rx_byte_a", 32'(rx_byte_a), 32'd0);
    check("rst_mid_rx_byte_c", 32'(rx_byte_c), 32'd0);
    check("rst_mid_rx_done", 32'({rx_done_a, rx_done_c}), 32'd0);
    check("rst_mid_flags", 32'({perr_a, ferr_a, perr_c, ferr_c}), 32'd0);
    rx_c = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("rst_no_tx_done", 32'(n_txdone_a - snap_tx), 32'd0);
    check("rst_no_rx_done", 32'((n_rxdone_a - snap_rx) + (n_rxdone_c - snap_rxc)), 32'd0);

    // ---- frames after reset release
    start_a = 1'b1;
    byte_a  = 8'h3C;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (880) @(posedge clk);
    @(negedge clk);
    check("post_rst_tx_done", 32'(n_txdone_a - snap_tx), 32'd1);
    check("post_rst_rx_count_a", 32'(n_rxdone_a - snap_rx), 32'd1);
    check("post_rst_rx_byte_a", 32'(rx_byte_a), 32'h3C);
    @(posedge clk);
    #1;
    send_c(7'h6B, 1'b0, 1'b1, 1'b1);
    rx_c = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("post_rst_rx_count_c", 32'(n_rxdone_c - snap_rxc), 32'd1);
    check("post_rst_rx_byte_c", 32'(rx_byte_c), 32'h6B);
    check("post_rst_rx_flags_c", 32'({perr_c, ferr_c}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
